// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg
//   Shared definitions for the multi-cycle data-memory responder:
//   FSM state encoding, legal LATENCY range and the address fault check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;

  // An access faults when it is not word aligned or falls past the last word.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input int unsigned depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ({32'd0, addr} >= (64'(depth_words) * 64'd4));
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// dmem_word_array
//   Synchronous single-port word store. The addressed word is read into
//   rdata on every rising edge; a write in the same cycle lands after the
//   read, so rdata carries the old contents (read-before-write).
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   idx    word index
//   wdata  word to write
//   rdata  registered read data
module dmem_word_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Read the old word and optionally overwrite it on the same edge.
  always_ff @(posedge clk) begin
    rdata <= mem_r[idx];
    if (we) begin
      mem_r[idx] <= wdata;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Multi-cycle data memory behind the MEM stage. A load/store seen in IDLE
//   is latched, MemStall freezes the pipeline for LATENCY cycles, and the
//   access executes on the edge entering DONE. Misaligned or out-of-range
//   accesses never write, return 0 for loads and pulse AddrError in DONE.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   MemRead, MemWrite   request (both set = store with read-before-write)
//   Address, WriteData  byte address and store data
//   ReadData            load result, valid in DONE and held afterwards
//   MemStall            combinational freeze request
//   AddrError           one-cycle fault pulse in DONE
//   Busy                high in BUSY and DONE
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemStall,
  output logic        AddrError,
  output logic        Busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Out-of-range LATENCY values are pulled back into the supported window.
  localparam int LAT_C = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                         (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [3:0] LAT_M1 = 4'(LAT_C - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rd_hold_r;
  logic        op_read_r;
  logic        op_write_r;
  logic        aerr_r;
  logic        busy_r;

  logic        req_s;
  logic        accept_s;
  logic        enter_done_s;
  logic [31:0] cur_addr_s;
  logic [31:0] cur_wdata_s;
  logic        cur_read_s;
  logic        cur_write_s;
  logic        cur_err_s;
  logic        we_s;
  logic [31:0] rdata_s;

  // Pick the operand set driving the array and decode the access strobes.
  // In IDLE the live request is used so a LATENCY=1 access can execute on
  // the very edge that latches it; afterwards only the latched copy counts.
  always_comb begin
    req_s    = MemRead | MemWrite;
    accept_s = (state_r == IDLE) && req_s;
    if (state_r == IDLE) begin
      cur_addr_s  = Address;
      cur_wdata_s = WriteData;
      cur_read_s  = MemRead;
      cur_write_s = MemWrite;
    end else begin
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_read_s  = op_read_r;
      cur_write_s = op_write_r;
    end
    cur_err_s = addr_error(cur_addr_s, DEPTH_WORDS);
    if (state_r == IDLE) begin
      enter_done_s = req_s && (LAT_C == 1);
    end else if (state_r == BUSY) begin
      enter_done_s = (cnt_r <= 4'd1);
    end else begin
      enter_done_s = 1'b0;
    end
    // Reset gating keeps a store from landing on an edge seen during reset.
    we_s     = enter_done_s && cur_write_s && !cur_err_s && !reset;
    MemStall = accept_s || (state_r == BUSY);
  end

  // Load data is presented straight from the array in DONE, then held.
  always_comb begin
    if ((state_r == DONE) && cur_read_s) begin
      ReadData = cur_err_s ? 32'd0 : rdata_s;
    end else begin
      ReadData = rd_hold_r;
    end
  end

  dmem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (we_s),
    .idx   (cur_addr_s[IDX_W+1:2]),
    .wdata (cur_wdata_s),
    .rdata (rdata_s)
  );

  // Access FSM with request latches. cnt_r counts BUSY cycles still to go;
  // it reaches 0 on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      op_read_r  <= 1'b0;
      op_write_r <= 1'b0;
      rd_hold_r  <= 32'd0;
      aerr_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      aerr_r <= enter_done_s && cur_err_s;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            addr_r     <= Address;
            wdata_r    <= WriteData;
            op_read_r  <= MemRead;
            op_write_r <= MemWrite;
            cnt_r      <= LAT_M1;
            state_r    <= (LAT_C > 1) ? BUSY : DONE;
            busy_r     <= 1'b1;
          end
        end
        BUSY: begin
          cnt_r <= (cnt_r == 4'd0) ? 4'd0 : cnt_r - 4'd1;
          if (cnt_r <= 4'd1) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          // The request still visible here is the one just served.
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          rd_hold_r <= ReadData;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign AddrError = aerr_r;
  assign Busy      = busy_r;

endmodule
